fwd_sel_ctrl: RTL and testbench

- Pipelined forwarding and load-use hazard controller for the 5-stage CPU.
- Tracks the destination registers of the instructions in EX and MEM.
- Produces the registered 2-bit select codes for the operand-A and operand-B 4-way operand muxes at the start of EX, plus a stall request for IF/ID.
- Sits between the ID stage and the EX-stage operand muxes.

---
 rtl/fwd_sel_ctrl.sv | 151 +++++++++++++++
 tb/tb_fwd_sel_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_sel_ctrl.sv
// Forwarding-select and load-use hazard controller sitting between ID and the EX operand muxes.
// Optional build macro FWD_STATS_EN adds saturating stall/forward statistics counters.
module fwd_sel_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ext_stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_alt_a,
  input  logic              id_alt_b,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_we,
`ifdef FWD_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt,
`endif
  output logic              stall_id
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] SEL_ALT = 2'b11;
  localparam logic [REG_AW-1:0] X0 = {REG_AW{1'b0}};

  // EX record lives on the output registers plus the load flag; MEM record is internal.
  logic              ex_load_r;
  logic              mem_valid_r;
  logic [REG_AW-1:0] mem_rd_r;
  logic              mem_we_r;

  logic [1:0]        sel_a_s;
  logic [1:0]        sel_b_s;
  logic              hazard_s;
  logic              bubble_s;

  // The EX-stage producer reaches MEM when the consumer reaches EX, hence 01; MEM producer -> WB gives 10.
  function automatic logic [1:0] op_sel(
    input logic              alt,
    input logic              use_rs,
    input logic [REG_AW-1:0] rs,
    input logic              exv,
    input logic              exwe,
    input logic [REG_AW-1:0] exrd,
    input logic              memv,
    input logic              memwe,
    input logic [REG_AW-1:0] memrd
  );
    logic [1:0] sel;
    if (alt) begin
      sel = SEL_ALT;
    end else if (use_rs && exv && exwe && (exrd != X0) && (exrd == rs)) begin
      sel = SEL_MEM;
    end else if (use_rs && memv && memwe && (memrd != X0) && (memrd == rs)) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Operand selects, load-use detection and bubble decision from current ID inputs.
  always_comb begin
    sel_a_s  = op_sel(id_alt_a, id_use_rs1, id_rs1, ex_valid, ex_we, ex_rd,
                      mem_valid_r, mem_we_r, mem_rd_r);
    sel_b_s  = op_sel(id_alt_b, id_use_rs2, id_rs2, ex_valid, ex_we, ex_rd,
                      mem_valid_r, mem_we_r, mem_rd_r);
    hazard_s = ex_valid && ex_we && ex_load_r && (ex_rd != X0) &&
               ((id_use_rs1 && !id_alt_a && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && !id_alt_b && (id_rs2 == ex_rd)));
    stall_id = hazard_s && id_valid && !flush;
    bubble_s = flush || stall_id || !id_valid;
  end

  // EX/MEM stage records and registered selects; everything holds while frozen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fwd_a       <= SEL_RF;
      fwd_b       <= SEL_RF;
      ex_valid    <= 1'b0;
      ex_rd       <= X0;
      ex_we       <= 1'b0;
      ex_load_r   <= 1'b0;
      mem_valid_r <= 1'b0;
      mem_rd_r    <= X0;
      mem_we_r    <= 1'b0;
    end else if (!ext_stall) begin
      mem_valid_r <= ex_valid;
      mem_rd_r    <= ex_rd;
      mem_we_r    <= ex_we;
      if (bubble_s) begin
        fwd_a     <= SEL_RF;
        fwd_b     <= SEL_RF;
        ex_valid  <= 1'b0;
        ex_rd     <= X0;
        ex_we     <= 1'b0;
        ex_load_r <= 1'b0;
      end else begin
        fwd_a     <= sel_a_s;
        fwd_b     <= sel_b_s;
        ex_valid  <= 1'b1;
        ex_rd     <= id_rd;
        ex_we     <= id_we;
        ex_load_r <= id_is_load;
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [1:0]  fwd_inc_s;
  logic [32:0] fwd_sum_s;

  // Number of operands granted a pipeline forward when the instruction enters EX.
  always_comb begin
    fwd_inc_s = 2'd0;
    if (!bubble_s) begin
      fwd_inc_s = {1'b0, (sel_a_s == SEL_MEM) || (sel_a_s == SEL_WB)} +
                  {1'b0, (sel_b_s == SEL_MEM) || (sel_b_s == SEL_WB)};
    end else begin
      fwd_inc_s = 2'd0;
    end
    fwd_sum_s = {1'b0, fwd_cnt} + {31'd0, fwd_inc_s};
  end

  // Saturating statistics counters, advanced only on non-frozen edges.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= 32'd0;
      fwd_cnt   <= 32'd0;
    end else if (!ext_stall) begin
      if (stall_id && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      fwd_cnt <= fwd_sum_s[32] ? 32'hFFFF_FFFF : fwd_sum_s[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Scoreboard bench for fwd_sel_ctrl: each step pushes its expected EX-stage outputs,
// which are popped and compared one edge later; stall_id is checked before the edge.
module tb_fwd_sel_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ext_stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_alt_a = 1'b0, id_alt_b = 1'b0;
  logic       id_we = 1'b0, id_is_load = 1'b0;
  logic [1:0] fwd_a, fwd_b;
  logic       ex_valid, ex_we, stall_id;
  logic [4:0] ex_rd;
`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  int chk = 0;
  int err = 0;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic       v;
    logic       we;
    logic [4:0] rd;
  } exp_t;

  typedef struct packed {
    logic v; logic [4:0] rs1; logic u1; logic aa;
    logic [4:0] rs2; logic u2; logic ab;
    logic [4:0] rd; logic we; logic ld; logic fl; logic xs;
    logic st; exp_t e;
  } step_t;

  exp_t  q[$];
  step_t steps[$];

  fwd_sel_ctrl #(.REG_AW(5)) dut (
    .clk(clk), .rstn(rstn), .ext_stall(ext_stall), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_alt_a(id_alt_a), .id_alt_b(id_alt_b), .id_rd(id_rd),
    .id_we(id_we), .id_is_load(id_is_load),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_we(ex_we),
`ifdef FWD_STATS_EN
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt),
`endif
    .stall_id(stall_id)
  );

  always #5 clk = ~clk;

  // Appends one ID-stage step with its expected stall and next-cycle EX outputs.
  task automatic add(input logic v, input logic [4:0] rs1, input logic u1, input logic aa,
                     input logic [4:0] rs2, input logic u2, input logic ab,
                     input logic [4:0] rd, input logic we, input logic ld,
                     input logic fl, input logic xs, input logic st,
                     input logic [1:0] ea, input logic [1:0] eb, input logic ev,
                     input logic ewe, input logic [4:0] erd);
    step_t s;
    s = '{v, rs1, u1, aa, rs2, u2, ab, rd, we, ld, fl, xs, st, '{ea, eb, ev, ewe, erd}};
    steps.push_back(s);
  endtask

  task automatic apply(input step_t s);
    id_valid = s.v; id_rs1 = s.rs1; id_use_rs1 = s.u1; id_alt_a = s.aa;
    id_rs2 = s.rs2; id_use_rs2 = s.u2; id_alt_b = s.ab;
    id_rd = s.rd; id_we = s.we; id_is_load = s.ld; flush = s.fl; ext_stall = s.xs;
  endtask

  task automatic idle2();
    add(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    add(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    chk++;
    if ({fwd_a, fwd_b, ex_valid, ex_we, ex_rd, stall_id} !== 12'd0) begin
      err++;
      $display("FAIL reset_state got fa=%b fb=%b v=%b we=%b rd=%0d st=%b want all 0",
               fwd_a, fwd_b, ex_valid, ex_we, ex_rd, stall_id);
    end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk) #1;
  endtask

  task automatic test_forwarding();
    step_t s; exp_t e;
    add(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd5);
    add(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 5'd6);
    add(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b1, 1'b1, 5'd8);
    idle2();
    add(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd0);
    add(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd4);
    add(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd10);
    add(1'b1, 5'd10, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 5'd11);
    add(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd3);
    add(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd3);
    add(1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 1'b1, 5'd20);
    for (int i = 0; i < steps.size(); i++) begin
      s = steps[i]; apply(s); q.push_back(s.e); #1;
      chk++;
      if (stall_id !== s.st) begin
        err++; $display("FAIL fwd_stall step %0d got %b want %b", i, stall_id, s.st);
      end
      @(posedge clk) #1;
      e = q.pop_front(); chk++;
      if ({fwd_a, fwd_b, ex_valid, ex_we} !== {e.a, e.b, e.v, e.we} || (e.v && ex_rd !== e.rd)) begin
        err++; $display("FAIL fwd_out step %0d got fa=%b fb=%b v=%b we=%b rd=%0d want fa=%b fb=%b v=%b we=%b rd=%0d",
                        i, fwd_a, fwd_b, ex_valid, ex_we, ex_rd, e.a, e.b, e.v, e.we, e.rd);
      end
    end
    steps.delete();
`ifdef FWD_STATS_EN
    chk++;
    if (fwd_cnt !== 32'd5) begin
      err++; $display("FAIL fwd_cnt_after_fwd got %0d want 5", fwd_cnt);
    end
`endif
  endtask

  task automatic test_load_use();
    step_t s; exp_t e;
    idle2();
    add(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd7);
    add(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    add(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 5'd9);
    for (int i = 0; i < steps.size(); i++) begin
      s = steps[i]; apply(s); q.push_back(s.e); #1;
      chk++;
      if (stall_id !== s.st) begin
        err++; $display("FAIL lu_stall step %0d got %b want %b", i, stall_id, s.st);
      end
      @(posedge clk) #1;
      e = q.pop_front(); chk++;
      if ({fwd_a, fwd_b, ex_valid, ex_we} !== {e.a, e.b, e.v, e.we} || (e.v && ex_rd !== e.rd)) begin
        err++; $display("FAIL lu_out step %0d got fa=%b fb=%b v=%b we=%b rd=%0d want fa=%b fb=%b v=%b we=%b rd=%0d",
                        i, fwd_a, fwd_b, ex_valid, ex_we, ex_rd, e.a, e.b, e.v, e.we, e.rd);
      end
    end
    steps.delete();
`ifdef FWD_STATS_EN
    chk++;
    if (stall_cnt !== 32'd1 || fwd_cnt !== 32'd6) begin
      err++; $display("FAIL stats_after_lu got stall=%0d fwd=%0d want stall=1 fwd=6", stall_cnt, fwd_cnt);
    end
`endif
  endtask

  task automatic test_flush_freeze();
    step_t s; exp_t e;
    idle2();
    add(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd12);
    add(1'b1, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    add(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd14);
    for (int k = 0; k < 3; k++)
      add(1'b1, 5'd14, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 5'd14);
    add(1'b1, 5'd14, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    add(1'b1, 5'd14, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 5'd15);
    for (int i = 0; i < steps.size(); i++) begin
      s = steps[i]; apply(s); q.push_back(s.e); #1;
      chk++;
      if (stall_id !== s.st) begin
        err++; $display("FAIL ff_stall step %0d got %b want %b", i, stall_id, s.st);
      end
      @(posedge clk) #1;
      e = q.pop_front(); chk++;
      if ({fwd_a, fwd_b, ex_valid, ex_we} !== {e.a, e.b, e.v, e.we} || (e.v && ex_rd !== e.rd)) begin
        err++; $display("FAIL ff_out step %0d got fa=%b fb=%b v=%b we=%b rd=%0d want fa=%b fb=%b v=%b we=%b rd=%0d",
                        i, fwd_a, fwd_b, ex_valid, ex_we, ex_rd, e.a, e.b, e.v, e.we, e.rd);
      end
    end
    steps.delete();
`ifdef FWD_STATS_EN
    chk++;
    if (stall_cnt !== 32'd2) begin
      err++; $display("FAIL stall_cnt_after_freeze got %0d want 2", stall_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_stall();
    step_t s; exp_t e;
    idle2();
    add(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd7);
    for (int i = 0; i < steps.size(); i++) begin
      s = steps[i]; apply(s); q.push_back(s.e);
      @(posedge clk) #1;
      e = q.pop_front(); chk++;
      if ({fwd_a, fwd_b, ex_valid, ex_we} !== {e.a, e.b, e.v, e.we} || (e.v && ex_rd !== e.rd)) begin
        err++; $display("FAIL rst_pre step %0d got fa=%b fb=%b v=%b we=%b rd=%0d", i, fwd_a, fwd_b, ex_valid, ex_we, ex_rd);
      end
    end
    steps.delete();
    add(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd9);
    apply(steps[0]); #1;
    chk++;
    if (stall_id !== 1'b1) begin
      err++; $display("FAIL rst_stall_before got %b want 1", stall_id);
    end
    rstn = 1'b0; #1;
    chk++;
    if ({fwd_a, fwd_b, ex_valid, ex_we, ex_rd, stall_id} !== 12'd0) begin
      err++; $display("FAIL rst_async got fa=%b fb=%b v=%b we=%b rd=%0d st=%b want all 0",
                      fwd_a, fwd_b, ex_valid, ex_we, ex_rd, stall_id);
    end
`ifdef FWD_STATS_EN
    chk++;
    if (stall_cnt !== 32'd0 || fwd_cnt !== 32'd0) begin
      err++; $display("FAIL stats_reset got stall=%0d fwd=%0d want 0", stall_cnt, fwd_cnt);
    end
`endif
    @(negedge clk) rstn = 1'b1;
    s = steps[0]; q.push_back(s.e); #1;
    chk++;
    if (stall_id !== 1'b0) begin
      err++; $display("FAIL rst_post_stall got %b want 0", stall_id);
    end
    @(posedge clk) #1;
    e = q.pop_front(); chk++;
    if ({fwd_a, fwd_b, ex_valid, ex_we, ex_rd} !== {e.a, e.b, e.v, e.we, e.rd}) begin
      err++; $display("FAIL rst_post_out got fa=%b fb=%b v=%b we=%b rd=%0d want fa=%b fb=%b v=%b we=%b rd=%0d",
                      fwd_a, fwd_b, ex_valid, ex_we, ex_rd, e.a, e.b, e.v, e.we, e.rd);
    end
    steps.delete();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_flush_freeze();
    test_reset_mid_stall();
    chk++;
    if (q.size() != 0) begin
      err++; $display("FAIL scoreboard_drain got %0d left want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
